// File: rtl/idct_first_if.sv
// Handshake bundle for idct_first: coefficient word in, sample word out.
interface idct_first_if;
  logic [63:0] in;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out;
  logic        out_valid;
  logic        out_ready;

  modport master (output in, output in_valid, input in_ready,
                  input out, input out_valid, output out_ready);
  modport slave  (input in, input in_valid, output in_ready,
                  output out, output out_valid, input out_ready);
endinterface

// File: rtl/idct_first.sv
// 8-point 1-D IDCT, one output sample per cycle, fixed latency 8.
// Optional build macro IDCT_FIRST_LEVEL_SHIFT_EN: emit unsigned samples (+128).
module idct_first (
  input logic         clk,
  input logic         rst_n,
  idct_first_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [2:0]         n;
  logic [63:0]        coef_q;
  logic [63:0]        out_q;
  logic signed [19:0] acc;
  logic signed [19:0] rnd;
  logic signed [19:0] shifted;
  logic signed [7:0]  xk;
  logic signed [15:0] prod;
  logic [7:0]         sat;
  logic [7:0]         sample;

  // Cosine basis T[k][idx] folded onto the first quadrant of cos(p*pi/16).
  function automatic logic signed [7:0] tcoef(input int unsigned k, input int unsigned idx);
    int unsigned p;
    int          mag;
    logic        neg;
    if (k == 0) return 8'sd45;
    p = ((2 * idx + 1) * k) % 32;
    if (p > 16) p = 32 - p;
    neg = (p > 8);
    if (neg) p = 16 - p;
    case (p)
      0:       mag = 64;
      1:       mag = 63;
      2:       mag = 59;
      3:       mag = 53;
      4:       mag = 45;
      5:       mag = 36;
      6:       mag = 24;
      7:       mag = 12;
      default: mag = 0;
    endcase
    return neg ? 8'(-mag) : 8'(mag);
  endfunction

  always_comb begin
    acc  = '0;
    xk   = '0;
    prod = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      xk   = coef_q[(7 - k) * 8 +: 8];
      prod = xk * tcoef(k, {29'd0, n});
      acc  = acc + {{4{prod[15]}}, prod};
    end
  end

  always_comb begin
    rnd     = acc + 20'sd64;
    shifted = rnd >>> 7;
    if (shifted > 20'sd127)
      sat = 8'h7F;
    else if (shifted < -20'sd128)
      sat = 8'h80;
    else
      sat = shifted[7:0];
`ifdef IDCT_FIRST_LEVEL_SHIFT_EN
    sample = sat ^ 8'h80;
`else
    sample = sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out       = out_q;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = CALC;
      end
      CALC: if (n == 3'd7) state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Each CALC cycle overwrites only byte n; other bytes keep their old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n      <= '0;
      coef_q <= '0;
      out_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          n <= '0;
          if (bus.in_valid) coef_q <= bus.in;
        end
        CALC: begin
          out_q[{3'd7 - n, 3'b000} +: 8] <= sample;
          n <= n + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_first.sv
// Self-checking bench for idct_first: spec vectors, handshake corners, random vs cosine model.
module tb_idct_first;

`ifdef IDCT_FIRST_LEVEL_SHIFT_EN
  localparam logic [63:0] LS = 64'h8080808080808080;
`else
  localparam logic [63:0] LS = 64'h0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  idct_first_if bus ();

  idct_first dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] din;
    logic [63:0] dexp;
    logic [63:0] mask;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int tval(input int k, input int n);
    real c;
    if (k == 0) return 45;
    c = 64.0 * $cos(3.14159265358979 * real'((2 * n + 1) * k) / 16.0);
    return int'(c);
  endfunction

  function automatic logic [63:0] model(input logic [63:0] x);
    logic [63:0] r;
    logic [7:0]  xb;
    int          acc, s;
    r = '0;
    for (int n = 0; n < 8; n++) begin
      acc = 0;
      for (int k = 0; k < 8; k++) begin
        xb  = x[(7 - k) * 8 +: 8];
        acc = acc + int'($signed(xb)) * tval(k, n);
      end
      s = (acc + 64) >>> 7;
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      r[(7 - n) * 8 +: 8] = 8'(s);
    end
    return r ^ LS;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] din);
    int w = 0;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in       = din;
    tick();
    bus.in_valid = 1'b0;
    bus.in       = {$urandom, $urandom};
  endtask

  // Wait for out_valid after an accept; checks latency and in_ready low meanwhile.
  task automatic wait_out(input string nm);
    int   lat = 0;
    logic rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    if (bus.in_ready) rdy_seen = 1'b1;
    chk({nm, "_latency"}, 64'(lat), 64'd8);
    chk({nm, "_in_ready_low"}, 64'(rdy_seen), 64'd0);
  endtask

  task automatic finish_out(input string nm);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    chk({nm, "_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_txn(input string nm, input logic [63:0] din, input logic [63:0] exp,
                         input logic [63:0] mask, input int stall);
    logic [63:0] held;
    send(din);
    wait_out(nm);
    held = bus.out;
    chk({nm, "_out"}, held & mask, exp & mask);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({nm, "_stall_out"}, bus.out, held);
      chk({nm, "_stall_valid"}, 64'(bus.out_valid), 64'd1);
    end
    finish_out(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[5];
    logic [63:0] w, seen;
    int          leaked;

    vt[0] = '{64'h4000000000000000, 64'h1717171717171717, '1};
    vt[1] = '{64'h0000000000000000, 64'h0000000000000000, '1};
    vt[2] = '{64'h7F7F7F7F7F7F7F7F, 64'h7F000000000000_09, 64'hFF000000000000FF};
    vt[3] = '{64'h8000000000000000, 64'hD3D3D3D3D3D3D3D3, '1};
    vt[4] = '{64'h0040000000000000, 64'h201B1206FAEEE6E1, '1};

    bus.in        = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", bus.out, 64'd0);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 5; i++)
      run_txn($sformatf("vec%0d", i), vt[i].din, vt[i].dexp ^ LS, vt[i].mask, i % 3);

    // Backpressure with a competing input word held during DONE.
    send(64'h4000000000000000);
    wait_out("bp");
    bus.in_valid = 1'b1;
    bus.in       = 64'h8000000000000000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_stable", bus.out, 64'h1717171717171717 ^ LS);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    finish_out("bp");
    tick();
    bus.in_valid = 1'b0;
    bus.in       = {$urandom, $urandom};
    chk("bp_second_accepted", 64'(bus.in_ready), 64'd0);
    wait_out("bp2");
    chk("bp2_out", bus.out, 64'hD3D3D3D3D3D3D3D3 ^ LS);
    finish_out("bp2");

    // Reset during CALC after three samples have been produced.
    send(64'h7F7F7F7F7F7F7F7F);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out", bus.out, 64'd0);
    chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    tick();
    rst_n  = 1'b1;
    leaked = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid) leaked++;
    end
    chk("rst_mid_no_leak", 64'(leaked), 64'd0);
    w = 64'h10F0_2233_C4E5_0A7B;
    run_txn("post_rst", w, model(w), '1, 0);

    for (int i = 0; i < 30; i++) begin
      w = {$urandom, $urandom};
      run_txn($sformatf("rnd%0d", i), w, model(w), '1, int'($urandom_range(0, 3)));
    end

    seen = bus.out;
    repeat (3) tick();
    chk("idle_out_hold", bus.out, seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idct_first.md
IDCT_FIRST -- requirements
Module: idct_first

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have in  in  64  eight signed 8-bit DCT coefficients X0..X7; X0 in [63:56], X7 in [7:0].
REQ-004 SHALL have in_valid  in  1  coefficient word valid.
REQ-005 SHALL have in_ready  out  1  block can accept a word.
REQ-006 SHALL have out  out  64  eight 8-bit samples x0..x7; x0 in [63:56], x7 in [7:0].
REQ-007 SHALL have out_valid  out  1  sample word valid.
REQ-008 SHALL have out_ready  in  1  downstream accepts sample word.

Function
REQ-009 SHALL implement FSM states IDLE, CALC, DONE.
REQ-010 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-011 SHALL, on an edge with in_valid&in_ready, register in and go IDLE->CALC with sample index n=0.
REQ-012 SHALL, in CALC, compute one sample x[n] per cycle, store it in its out byte, increment n; after n=7 go to DONE.
REQ-013 SHALL assert out_valid on the 8th edge after the accepting edge (fixed latency 8, no bubbles).
REQ-014 SHALL compute acc[n] = sum over k=0..7 of Xk*T[k][n], signed, at least 18 bits, no overflow.
REQ-015 SHALL use T[0][n]=45; for k>=1, T[k][n]=round(64*cos((2n+1)*k*pi/16)), with magnitudes 63,59,53,45,36,24,12 for cos arguments k'*pi/16, k'=1..7, signs from the cosine.
REQ-016 SHALL form sample = (acc+64) arithmetic-shifted right by 7 (floor), saturated to [-128,127].
REQ-017 SHALL hold out and out_valid stable in DONE while out_ready=0, and ignore in_valid.
REQ-018 SHALL, on an edge with out_valid&out_ready, go DONE->IDLE; in_ready rises the following cycle (no same-cycle accept).
REQ-019 SHALL keep out unchanged in IDLE and CALC until the new byte for each index is written.
REQ-020 SHALL ignore in changes after acceptance; only the registered copy is used.

Reset
REQ-021 SHALL, on rst_n low, asynchronously force state=IDLE, n=0, out=0, out_valid=0, coefficient register=0.
REQ-022 SHALL drive in_ready=1 from the first edge after rst_n is released.
REQ-023 SHALL abort any CALC/DONE transaction on reset mid-operation; the aborted word is never output.

Configuration
REQ-024 SHALL support macro IDCT_FIRST_LEVEL_SHIFT_EN.
REQ-025 SHALL, with IDCT_FIRST_LEVEL_SHIFT_EN defined, add 128 to each saturated sample (output unsigned 0..255, i.e. MSB inverted).
REQ-026 SHALL, without the macro, output the saturated sample as signed two's complement; latency and handshake unchanged in both builds.

Verification
REQ-027 DC only: in=0x4000000000000000 -> out=0x1717171717171717 (0x9797979797979797 with level shift), out_valid 8 cycles after accept.
REQ-028 All zero: in=0 -> out=0 (0x8080808080808080 with level shift); in_ready low for exactly CALC+DONE duration.
REQ-029 Saturation: in=0x7F7F7F7F7F7F7F7F -> out[63:56]=0x7F (x0 saturated from 334), out[7:0]=0x09.
REQ-030 Negative floor: in=0x8000000000000000 -> every byte 0xD3 (-45); level shift build 0x53.
REQ-031 Backpressure: hold out_ready=0 for 5 cycles in DONE while presenting a second in_valid word -> out stable, in_ready=0, second word accepted only after out handshake plus one cycle.
REQ-032 Reset during CALC at n=3 -> out=0, out_valid=0 immediately; next word processed normally with latency 8.
